// File: rtl/mux_n_reg_hs_if.sv
// mux_n_reg_hs_if
// Bundles the streaming handshake and select-control signals of the
// registered N:1 multiplexer.
//   din        : flattened input channels, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   din_valid  : per-channel valid
//   din_ready  : per-channel ready (driven by the mux)
//   sel_in     : requested channel
//   sel_load   : load strobe for sel_in
//   sel_cur    : currently active channel
//   sel_err    : one-cycle pulse after a rejected select load
//   dout       : registered output data
//   dout_valid : output valid
//   dout_ready : sink ready
// The slave modport is the multiplexer's view; the master modport is the
// view of whatever drives the sources, the select and the sink.
interface mux_n_reg_hs_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_IN     = 4
);
    localparam int SEL_WIDTH = $clog2(NUM_IN);

    logic [NUM_IN*DATA_WIDTH-1:0] din;
    logic [NUM_IN-1:0]            din_valid;
    logic [NUM_IN-1:0]            din_ready;
    logic [SEL_WIDTH-1:0]         sel_in;
    logic                         sel_load;
    logic [SEL_WIDTH-1:0]         sel_cur;
    logic                         sel_err;
    logic [DATA_WIDTH-1:0]        dout;
    logic                         dout_valid;
    logic                         dout_ready;

    modport master (
        output din, din_valid, sel_in, sel_load, dout_ready,
        input  din_ready, sel_cur, sel_err, dout, dout_valid
    );

    modport slave (
        input  din, din_valid, sel_in, sel_load, dout_ready,
        output din_ready, sel_cur, sel_err, dout, dout_valid
    );
endinterface

// File: rtl/mux_n_reg_hs.sv
// mux_n_reg_hs
// Parametrised N-input, W-bit multiplexer with a single output register
// stage and valid/ready flow control on every input and on the output.
// The active channel is a registered value loaded through sel_in/sel_load;
// out-of-range loads are ignored and reported on sel_err.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : mux_n_reg_hs_if slave modport (data, handshakes, select control)
module mux_n_reg_hs #(
    parameter int  DATA_WIDTH = 8,
    parameter int  NUM_IN     = 4,
    localparam int SEL_WIDTH  = $clog2(NUM_IN)
) (
    input logic           clk,
    input logic           rst,
    mux_n_reg_hs_if.slave bus
);
    localparam logic [SEL_WIDTH:0] NUM_IN_EXT = (SEL_WIDTH + 1)'(NUM_IN);

    logic                  sel_in_range;
    logic                  out_free;
    logic                  can_accept;
    logic                  sel_valid;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_data;

    // Zero-extend before comparing so NUM_IN itself is representable.
    assign sel_in_range = ({1'b0, bus.sel_in} < NUM_IN_EXT);

    // The output register can take a new beat if it is empty or being drained.
    assign out_free = !bus.dout_valid || bus.dout_ready;

    // No beat is accepted during reset or in any cycle carrying a select load,
    // so a select change never lands in the middle of a beat.
    assign can_accept = !rst && !bus.sel_load && out_free;

    always_comb begin
        sel_data      = '0;
        sel_valid     = 1'b0;
        bus.din_ready = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (bus.sel_cur == SEL_WIDTH'(k)) begin
                sel_data         = bus.din[k*DATA_WIDTH +: DATA_WIDTH];
                sel_valid        = bus.din_valid[k];
                bus.din_ready[k] = can_accept;
            end
        end
    end

    assign accept = sel_valid && can_accept;

    // Output register: replace on accept, otherwise clear valid on drain.
    // dout keeps its last value after a drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
        end else if (accept) begin
            bus.dout       <= sel_data;
            bus.dout_valid <= 1'b1;
        end else if (bus.dout_valid && bus.dout_ready) begin
            bus.dout_valid <= 1'b0;
        end
    end

    // Select register and rejected-load pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.sel_cur <= '0;
            bus.sel_err <= 1'b0;
        end else begin
            bus.sel_err <= bus.sel_load && !sel_in_range;
            if (bus.sel_load && sel_in_range) begin
                bus.sel_cur <= bus.sel_in;
            end
        end
    end
endmodule
